// File: rtl/mem_bus_arbiter_if.sv
// Request/grant handshakes of the CPU (C) and secondary master (D) plus the
// shared synchronous memory port, as seen by the arbiter (slave) and its users (master).
interface mem_bus_arbiter_if;
   logic        c_req;
   logic        c_we;
   logic        c_lock;
   logic [19:0] c_addr;
   logic [7:0]  c_wdata;
   logic        c_gnt;
   logic        c_rvalid;
   logic [7:0]  c_rdata;

   logic        d_req;
   logic        d_we;
   logic [19:0] d_addr;
   logic [7:0]  d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [7:0]  d_rdata;

   logic [19:0] address;
   logic [7:0]  out;
   logic        wren;
   logic [7:0]  data;
   logic        owner;

   modport master (
      output c_req, c_we, c_lock, c_addr, c_wdata,
      output d_req, d_we, d_addr, d_wdata,
      input  c_gnt, c_rvalid, c_rdata,
      input  d_gnt, d_rvalid, d_rdata,
      input  address, out, wren, owner,
      output data
   );

   modport slave (
      input  c_req, c_we, c_lock, c_addr, c_wdata,
      input  d_req, d_we, d_addr, d_wdata,
      output c_gnt, c_rvalid, c_rdata,
      output d_gnt, d_rvalid, d_rdata,
      output address, out, wren, owner,
      input  data
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for a 20-bit address / 8-bit data synchronous memory with
// CPU priority, aging-based anti-starvation for D, CPU bus lock and a 2-stage read return tag.
module mem_bus_arbiter #(
   parameter int unsigned MAX_WAIT = 15,
   parameter int unsigned WAIT_W   = 8
) (
   input  logic             clock,
   input  logic             reset,
   mem_bus_arbiter_if.slave bus
);

   localparam logic [WAIT_W-1:0] AGE_LIMIT = WAIT_W'(MAX_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_SAT  = {WAIT_W{1'b1}};
   localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};

   logic              c_gnt_s;
   logic              d_gnt_s;
   logic              age_hit_s;

   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

   logic [19:0]       address_q, address_d;
   logic [7:0]        out_q, out_d;
   logic              wren_q, wren_d;
   logic              owner_q, owner_d;

   logic              s1_valid_q, s1_valid_d;
   logic              s1_owner_q, s1_owner_d;
   logic              s2_valid_q, s2_valid_d;
   logic              s2_owner_q, s2_owner_d;

   logic              c_rvalid_q, c_rvalid_d;
   logic [7:0]        c_rdata_q, c_rdata_d;
   logic              d_rvalid_q, d_rvalid_d;
   logic [7:0]        d_rdata_q, d_rdata_d;

   assign age_hit_s = (wait_cnt_q >= AGE_LIMIT);

   // D takes the bus only when C is idle or D has aged out, and never under lock.
   always_comb begin
      c_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
      if (reset) begin
         c_gnt_s = 1'b0;
         d_gnt_s = 1'b0;
      end else begin
         d_gnt_s = bus.d_req && !bus.c_lock && (!bus.c_req || age_hit_s);
         c_gnt_s = bus.c_req && !d_gnt_s;
      end
   end

   // Aging counter: counts cycles D is kept waiting, saturating while blocked.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!bus.d_req || d_gnt_s) begin
         wait_cnt_d = {WAIT_W{1'b0}};
      end else if (wait_cnt_q != WAIT_SAT) begin
         wait_cnt_d = wait_cnt_q + WAIT_ONE;
      end else begin
         wait_cnt_d = wait_cnt_q;
      end
   end

   // Bus stage: the winner's request is launched to memory at the transfer edge.
   always_comb begin
      address_d = address_q;
      out_d     = out_q;
      wren_d    = 1'b0;
      owner_d   = owner_q;
      case ({d_gnt_s, c_gnt_s})
         2'b01: begin
            address_d = bus.c_addr;
            out_d     = bus.c_wdata;
            wren_d    = bus.c_we;
            owner_d   = 1'b0;
         end
         2'b10: begin
            address_d = bus.d_addr;
            out_d     = bus.d_wdata;
            wren_d    = bus.d_we;
            owner_d   = 1'b1;
         end
         default: begin
            address_d = address_q;
            out_d     = out_q;
            wren_d    = 1'b0;
            owner_d   = owner_q;
         end
      endcase
   end

   // Read tag travels alongside the memory latency so the returning byte
   // lands on the requester that issued it, two edges after acceptance.
   always_comb begin
      s1_valid_d = (c_gnt_s && !bus.c_we) || (d_gnt_s && !bus.d_we);
      s1_owner_d = d_gnt_s;
      s2_valid_d = s1_valid_q;
      s2_owner_d = s1_owner_q;
      c_rvalid_d = s2_valid_q && !s2_owner_q;
      d_rvalid_d = s2_valid_q && s2_owner_q;
      c_rdata_d  = c_rdata_q;
      d_rdata_d  = d_rdata_q;
      if (c_rvalid_d) begin
         c_rdata_d = bus.data;
      end else begin
         c_rdata_d = c_rdata_q;
      end
      if (d_rvalid_d) begin
         d_rdata_d = bus.data;
      end else begin
         d_rdata_d = d_rdata_q;
      end
   end

   // State registers; reset drops any reads still in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wait_cnt_q <= {WAIT_W{1'b0}};
         address_q  <= 20'h00000;
         out_q      <= 8'h00;
         wren_q     <= 1'b0;
         owner_q    <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_owner_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_owner_q <= 1'b0;
         c_rvalid_q <= 1'b0;
         c_rdata_q  <= 8'h00;
         d_rvalid_q <= 1'b0;
         d_rdata_q  <= 8'h00;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         address_q  <= address_d;
         out_q      <= out_d;
         wren_q     <= wren_d;
         owner_q    <= owner_d;
         s1_valid_q <= s1_valid_d;
         s1_owner_q <= s1_owner_d;
         s2_valid_q <= s2_valid_d;
         s2_owner_q <= s2_owner_d;
         c_rvalid_q <= c_rvalid_d;
         c_rdata_q  <= c_rdata_d;
         d_rvalid_q <= d_rvalid_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   assign bus.c_gnt    = c_gnt_s;
   assign bus.d_gnt    = d_gnt_s;
   assign bus.address  = address_q;
   assign bus.out      = out_q;
   assign bus.wren     = wren_q;
   assign bus.owner    = owner_q;
   assign bus.c_rvalid = c_rvalid_q;
   assign bus.c_rdata  = c_rdata_q;
   assign bus.d_rvalid = d_rvalid_q;
   assign bus.d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: a transaction-level model (grant rule,
// aging count, memory image, queue of due read returns) is compared every cycle.
module tb_mem_bus_arbiter;
   localparam int MAX_WAIT = 15;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   mem_bus_arbiter_if bus_if ();

   mem_bus_arbiter #(.MAX_WAIT(MAX_WAIT), .WAIT_W(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
   endtask

   function automatic logic [7:0] mem_default(input logic [19:0] a);
      case (a)
         20'h12345: return 8'hA5;
         20'h00001: return 8'h11;
         20'h00002: return 8'h22;
         default:   return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]};
      endcase
   endfunction

   // Synchronous memory: read-first, one edge of latency.
   bit [7:0] tb_mem [0:1048575];
   bit       tb_wr  [0:1048575];
   always @(posedge clock) begin
      bus_if.data <= tb_wr[bus_if.address] ? tb_mem[bus_if.address] : mem_default(bus_if.address);
      if (bus_if.wren === 1'b1) begin
         tb_mem[bus_if.address] <= bus_if.out;
         tb_wr[bus_if.address]  <= 1'b1;
      end
   end

   // Reference model
   typedef struct {
      int         due;
      logic       own;
      logic [7:0] data;
   } ret_t;

   ret_t        ret_q[$];
   logic [7:0]  m_mem [logic [19:0]];
   int          cyc    = 0;
   int          m_wait = 0;
   logic [19:0] m_addr = 20'h0;
   logic [7:0]  m_out  = 8'h0;
   logic        m_wren = 1'b0;
   logic        m_owner = 1'b0;
   logic [7:0]  m_crd  = 8'h0;
   logic [7:0]  m_drd  = 8'h0;

   function automatic logic [7:0] m_read(input logic [19:0] a);
      return m_mem.exists(a) ? m_mem[a] : mem_default(a);
   endfunction

   always @(negedge clock) begin : model_cmp
      logic        ev_c, ev_d, eg_c, eg_d, we;
      logic [19:0] a;
      logic [7:0]  wd;
      ret_t        e;
      ev_c = 1'b0; ev_d = 1'b0; eg_c = 1'b0; eg_d = 1'b0;
      if (reset !== 1'b0) begin
         m_addr = 20'h0; m_out = 8'h0; m_wren = 1'b0; m_owner = 1'b0;
         m_crd = 8'h0; m_drd = 8'h0; m_wait = 0;
         ret_q.delete();
      end else begin
         while (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            e = ret_q.pop_front();
            if (e.own) begin ev_d = 1'b1; m_drd = e.data; end
            else       begin ev_c = 1'b1; m_crd = e.data; end
         end
         eg_d = bus_if.d_req && !bus_if.c_lock && (!bus_if.c_req || m_wait >= MAX_WAIT);
         eg_c = bus_if.c_req && !eg_d;
      end
      chk("c_gnt",    {31'h0, bus_if.c_gnt},    {31'h0, eg_c});
      chk("d_gnt",    {31'h0, bus_if.d_gnt},    {31'h0, eg_d});
      chk("address",  {12'h0, bus_if.address},  {12'h0, m_addr});
      chk("out",      {24'h0, bus_if.out},      {24'h0, m_out});
      chk("wren",     {31'h0, bus_if.wren},     {31'h0, m_wren});
      chk("owner",    {31'h0, bus_if.owner},    {31'h0, m_owner});
      chk("c_rvalid", {31'h0, bus_if.c_rvalid}, {31'h0, ev_c});
      chk("c_rdata",  {24'h0, bus_if.c_rdata},  {24'h0, m_crd});
      chk("d_rvalid", {31'h0, bus_if.d_rvalid}, {31'h0, ev_d});
      chk("d_rdata",  {24'h0, bus_if.d_rdata},  {24'h0, m_drd});
      if (reset === 1'b0) begin
         if (eg_c || eg_d) begin
            a  = eg_d ? bus_if.d_addr  : bus_if.c_addr;
            we = eg_d ? bus_if.d_we    : bus_if.c_we;
            wd = eg_d ? bus_if.d_wdata : bus_if.c_wdata;
            m_addr = a; m_out = wd; m_wren = we; m_owner = eg_d;
            if (we) m_mem[a] = wd;
            else    ret_q.push_back('{cyc + 3, eg_d, m_read(a)});
         end else begin
            m_wren = 1'b0;
         end
         if (!bus_if.d_req || eg_d) m_wait = 0;
         else if (m_wait < 255)     m_wait = m_wait + 1;
      end
      cyc++;
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic c_drive(input logic req, input logic we, input logic [19:0] a, input logic [7:0] wd);
      bus_if.c_req = req; bus_if.c_we = we; bus_if.c_addr = a; bus_if.c_wdata = wd;
   endtask

   task automatic d_drive(input logic req, input logic we, input logic [19:0] a, input logic [7:0] wd);
      bus_if.d_req = req; bus_if.d_we = we; bus_if.d_addr = a; bus_if.d_wdata = wd;
   endtask

   initial begin
      int   dg_cnt, dg_first, dg_prev, dg_gap_bad, blocked;
      logic ca, da;
      reset = 1'b1;
      c_drive(1'b0, 1'b0, 20'h0, 8'h0);
      d_drive(1'b0, 1'b0, 20'h0, 8'h0);
      bus_if.c_lock = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      repeat (2) step();

      // C read of 0x12345 with D idle
      c_drive(1'b1, 1'b0, 20'h12345, 8'h00);
      @(negedge clock); chk("t1_c_gnt", {31'h0, bus_if.c_gnt}, 32'd1);
      step(); c_drive(1'b0, 1'b0, 20'h0, 8'h0);
      @(negedge clock);
      chk("t1_address", {12'h0, bus_if.address}, 32'h12345);
      chk("t1_wren", {31'h0, bus_if.wren}, 32'd0);
      step(); step();
      @(negedge clock);
      chk("t1_c_rvalid", {31'h0, bus_if.c_rvalid}, 32'd1);
      chk("t1_c_rdata", {24'h0, bus_if.c_rdata}, 32'hA5);
      chk("t1_d_rvalid", {31'h0, bus_if.d_rvalid}, 32'd0);
      step(); @(negedge clock); chk("t1_pulse_end", {31'h0, bus_if.c_rvalid}, 32'd0);
      step();

      // Write 0x3C to 0x00100 then read it back-to-back
      c_drive(1'b1, 1'b1, 20'h00100, 8'h3C);
      @(negedge clock); chk("t2_wr_gnt", {31'h0, bus_if.c_gnt}, 32'd1);
      step(); c_drive(1'b1, 1'b0, 20'h00100, 8'h00);
      @(negedge clock); chk("t2_wren_hi", {31'h0, bus_if.wren}, 32'd1);
      step(); c_drive(1'b0, 1'b0, 20'h0, 8'h0);
      @(negedge clock); chk("t2_wren_lo", {31'h0, bus_if.wren}, 32'd0);
      step(); step();
      @(negedge clock);
      chk("t2_c_rvalid", {31'h0, bus_if.c_rvalid}, 32'd1);
      chk("t2_c_rdata", {24'h0, bus_if.c_rdata}, 32'h3C);
      step(); step();

      // Interleaved reads: C at 0x00001, D at 0x00002
      c_drive(1'b1, 1'b0, 20'h00001, 8'h00);
      d_drive(1'b1, 1'b0, 20'h00002, 8'h00);
      @(negedge clock); chk("t5_c_first", {31'h0, bus_if.c_gnt}, 32'd1);
      step(); c_drive(1'b0, 1'b0, 20'h0, 8'h0);
      @(negedge clock); chk("t5_d_second", {31'h0, bus_if.d_gnt}, 32'd1);
      step(); d_drive(1'b0, 1'b0, 20'h0, 8'h0);
      step();
      @(negedge clock);
      chk("t5_c_rvalid", {31'h0, bus_if.c_rvalid}, 32'd1);
      chk("t5_c_rdata", {24'h0, bus_if.c_rdata}, 32'h11);
      chk("t5_d_quiet", {31'h0, bus_if.d_rvalid}, 32'd0);
      step();
      @(negedge clock);
      chk("t5_d_rvalid", {31'h0, bus_if.d_rvalid}, 32'd1);
      chk("t5_d_rdata", {24'h0, bus_if.d_rdata}, 32'h22);
      chk("t5_c_quiet", {31'h0, bus_if.c_rvalid}, 32'd0);
      step(); step();

      // Continuous contention: D once every MAX_WAIT+1 cycles
      c_drive(1'b1, 1'b0, 20'h00200, 8'h00);
      d_drive(1'b1, 1'b0, 20'h00300, 8'h00);
      dg_cnt = 0; dg_first = -1; dg_prev = -1; dg_gap_bad = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clock);
         if (bus_if.d_gnt) begin
            if (dg_cnt == 0) dg_first = i;
            else if (i - dg_prev != 16) dg_gap_bad++;
            dg_prev = i;
            dg_cnt++;
         end
         step();
      end
      c_drive(1'b0, 1'b0, 20'h0, 8'h0);
      d_drive(1'b0, 1'b0, 20'h0, 8'h0);
      chk("t3_d_grants", dg_cnt, 32'd4);
      chk("t3_first_d", dg_first, 32'd15);
      chk("t3_bad_gaps", dg_gap_bad, 32'd0);
      step(); step();

      // Lock with C idle: D held off, granted right after release
      bus_if.c_lock = 1'b1;
      d_drive(1'b1, 1'b0, 20'h00400, 8'h00);
      blocked = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (bus_if.d_gnt) blocked++;
         step();
      end
      chk("t4_blocked", blocked, 32'd0);
      bus_if.c_lock = 1'b0;
      @(negedge clock); chk("t4_d_after", {31'h0, bus_if.d_gnt}, 32'd1);
      step(); d_drive(1'b0, 1'b0, 20'h0, 8'h0); step();

      // Long lock with C busy: aging count must saturate, not wrap
      c_drive(1'b1, 1'b0, 20'h00500, 8'h00);
      d_drive(1'b1, 1'b0, 20'h00600, 8'h00);
      bus_if.c_lock = 1'b1;
      repeat (260) step();
      bus_if.c_lock = 1'b0;
      @(negedge clock);
      chk("t4_sat_d_gnt", {31'h0, bus_if.d_gnt}, 32'd1);
      chk("t4_sat_c_gnt", {31'h0, bus_if.c_gnt}, 32'd0);
      step();
      c_drive(1'b0, 1'b0, 20'h0, 8'h0);
      d_drive(1'b0, 1'b0, 20'h0, 8'h0);
      repeat (4) step();

      // Reset with a D read in flight
      d_drive(1'b1, 1'b0, 20'h00002, 8'h00);
      @(negedge clock); chk("t6_d_gnt", {31'h0, bus_if.d_gnt}, 32'd1);
      step(); d_drive(1'b0, 1'b0, 20'h0, 8'h0);
      reset = 1'b1;
      #1;
      chk("t6_address", {12'h0, bus_if.address}, 32'd0);
      chk("t6_owner", {31'h0, bus_if.owner}, 32'd0);
      chk("t6_wren", {31'h0, bus_if.wren}, 32'd0);
      chk("t6_d_rdata", {24'h0, bus_if.d_rdata}, 32'd0);
      step(); step();
      reset = 1'b0;
      blocked = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         if (bus_if.d_rvalid) blocked++;
         step();
      end
      chk("t6_no_rvalid", blocked, 32'd0);
      c_drive(1'b1, 1'b0, 20'h12345, 8'h00);
      @(negedge clock); chk("t6_c_gnt", {31'h0, bus_if.c_gnt}, 32'd1);
      step(); c_drive(1'b0, 1'b0, 20'h0, 8'h0);
      step(); step();
      @(negedge clock);
      chk("t6_c_rvalid", {31'h0, bus_if.c_rvalid}, 32'd1);
      chk("t6_c_rdata", {24'h0, bus_if.c_rdata}, 32'hA5);
      step();

      // Randomized traffic honouring the hold-until-accepted rule
      for (int n = 0; n < 2000; n++) begin
         @(negedge clock);
         ca = bus_if.c_gnt;
         da = bus_if.d_gnt;
         step();
         if (!bus_if.c_req || ca)
            c_drive($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                    20'($urandom_range(0, 15)), 8'($urandom));
         if (!bus_if.d_req || da)
            d_drive($urandom_range(0, 1) != 0, 1'($urandom_range(0, 1)),
                    20'($urandom_range(0, 15)), 8'($urandom));
         bus_if.c_lock = ($urandom_range(0, 7) == 0);
      end
      @(negedge clock);
      step();
      c_drive(1'b0, 1'b0, 20'h0, 8'h0);
      d_drive(1'b0, 1'b0, 20'h0, 8'h0);
      bus_if.c_lock = 1'b0;
      repeat (6) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 20-bit-address / 8-bit-data synchronous memory port between two requesters:
  - C: the CPU core, default priority.
  - D: a secondary master (DMA / video fetch).
- Valid/ready request handshake with pipelined accept (one transfer per clock) and fixed 1-cycle memory read latency.
- Aging counter prevents starvation of D; a lock input keeps D off the bus during CPU read-modify-write sequences.

Parameters:
- MAX_WAIT, 15, cycles D may wait (req high, not granted) before it receives priority; range 1..255.
- WAIT_W, 8, width of the aging counter.

Ports:
- clock  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-high reset
- c_req  in  1  CPU request valid
- c_we  in  1  CPU request is write
- c_lock  in  1  CPU holds bus; D not granted while high
- c_addr  in  20  CPU address
- c_wdata  in  8  CPU write data
- c_gnt  out  1  CPU request accepted this cycle (combinational)
- c_rvalid  out  1  CPU read data valid (pulse)
- c_rdata  out  8  CPU read data
- d_req, d_we, d_addr, d_wdata  in  1/1/20/8  D request, same meaning as CPU
- d_gnt  out  1  D request accepted this cycle (combinational)
- d_rvalid  out  1  D read data valid (pulse)
- d_rdata  out  8  D read data
- address  out  20  memory address (registered)
- out  out  8  memory write data (registered)
- wren  out  1  memory write enable (registered)
- data  in  8  memory read data; valid one edge after address is presented
- owner  out  1  0 = C, 1 = D; owner of transfer currently on the bus

Behaviour:
- Handshake: a transfer occurs at the posedge where x_req && x_gnt.
  - Requester holds req/we/addr/wdata stable until that edge.
  - Requester may present the next request in the following cycle; back-to-back transfers are legal.
- Grant logic, combinational, at most one of c_gnt/d_gnt high:
  - both gnts 0 while reset is high.
  - age_hit = (wait_cnt >= MAX_WAIT).
  - d_gnt = d_req && !c_lock && (!c_req || age_hit).
  - c_gnt = c_req && !d_gnt.
- c_lock rules:
  - c_lock high blocks D even when age_hit.
  - The aging counter saturates at 2^WAIT_W-1 while blocked.
- Aging counter wait_cnt:
  - clears on a D transfer or when d_req is low.
  - otherwise increments (saturating) when d_req is high and d_gnt is low.
- Bus stage (registered at the transfer edge E0):
  - address <= winner addr; out <= winner wdata; wren <= winner we; owner <= winner.
  - With no transfer: wren <= 0; address, out and owner hold.
- Read return tag pipeline:
  - Stage 1 at E0: valid = transfer && !we, plus owner.
  - Stage 2 at E1.
  - At E2: x_rdata <= data and x_rvalid <= 1 for the tagged owner only.
  - x_rvalid is high for exactly one cycle per read.
  - x_rdata holds its last value otherwise.
- Latency: request accepted at E0 -> memory samples address at E1 -> x_rvalid/x_rdata visible after E2.
- Writes produce no rvalid.
- Ordering:
  - Transfers reach memory strictly in grant order.
  - A read granted after a write to the same address returns the new data.
- Reset (asynchronous, any time, including with reads in flight):
  - address = 0, out = 0, wren = 0, owner = 0.
  - c_rvalid = d_rvalid = 0; c_rdata = d_rdata = 0.
  - Tag pipeline cleared; in-flight reads are dropped, no rvalid after release.
  - wait_cnt = 0.
- Simultaneous events:
  - Both requests without age_hit -> C wins.
  - A return pulse for one owner coincides freely with a new grant to the other.

Test Plan:
- C reads 0x12345 (memory byte 0xA5) with D idle:
  - c_gnt high in the request cycle.
  - address = 0x12345 and wren = 0 after E0.
  - c_rvalid = 1 with c_rdata = 0xA5 after E2; d_rvalid stays 0.
- C writes 0x3C to 0x00100, then reads 0x00100 back-to-back:
  - wren = 1 for one cycle, then 0.
  - c_rvalid after 2 edges from the read grant, c_rdata = 0x3C.
- C and D both request continuously, MAX_WAIT = 15:
  - D granted exactly once every 16 cycles.
  - wait_cnt resets after each D grant.
  - owner toggles accordingly.
- C holds c_lock = 1 with c_req low for 40 cycles while d_req is high:
  - d_gnt stays 0.
  - D is granted in the first cycle after c_lock drops.
- Interleaved reads, C at 0x00001 then D at 0x00002 on consecutive edges (data 0x11 / 0x22):
  - c_rvalid with 0x11, then d_rvalid with 0x22 one cycle later.
- Reset asserted one cycle after a D read grant:
  - all outputs 0 immediately.
  - no d_rvalid after release.
  - first post-reset C request granted normally.
